// File: rtl/panel_input_conditioner_pkg.sv
// Shared types for the front-panel input conditioner: channel map, idle levels and lockout states.
package panel_input_conditioner_pkg;

  localparam int NUM_KEYS = 10;
  // Channel order: keys [9:0], startn 10, stopn 11, clearn 12, door 13.
  localparam int NUM_CH = NUM_KEYS + 4;
  localparam logic [NUM_CH-1:0] CH_IDLE = {1'b0, 3'b111, {NUM_KEYS{1'b0}}};

  typedef logic [NUM_KEYS-1:0] key_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ONE  = 2'd1,
    LOCK = 2'd2
  } lock_state_t;

  function automatic logic is_one_hot(input key_t k);
    return (k != '0) && ((k & (k - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/panel_input_conditioner_debounce_cell.sv
// One input channel: synchroniser chain then a stable-level debouncer; no backpressure.
// A held change moves the level SYNC_STAGES + DEBOUNCE_CYCLES edges after first sampling.
module debounce_cell #(
  parameter int   DEBOUNCE_CYCLES = 4,
  parameter int   SYNC_STAGES     = 2,
  parameter logic IDLE_VALUE      = 1'b0
) (
  input  logic clock,
  input  logic resetn,
  input  logic raw,
  output logic level
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0]          cnt;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync  <= {SYNC_STAGES{IDLE_VALUE}};
      level <= IDLE_VALUE;
      cnt   <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], raw};
      // Any sample agreeing with the stable level restarts the count.
      if (sync[SYNC_STAGES-1] == level) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        level <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/panel_input_conditioner.sv
// Debounces keypad/buttons/door, enforces single-key lockout and stop/clear over start.
// Latency SYNC_STAGES + DEBOUNCE_CYCLES + 1 edges; pure level path, no backpressure.
module panel_input_conditioner
  import panel_input_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SYNC_STAGES     = 2
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic [NUM_KEYS-1:0] raw_keypad,
  input  logic                raw_startn,
  input  logic                raw_stopn,
  input  logic                raw_clearn,
  input  logic                raw_door_closed,
  output logic [NUM_KEYS-1:0] keypad,
  output logic                startn,
  output logic                stopn,
  output logic                clearn,
  output logic                door_closed,
  output logic                multi_key
);

  logic [NUM_CH-1:0] raw_all;
  logic [NUM_CH-1:0] db_all;
  key_t              k;
  lock_state_t       state;

  assign raw_all = {raw_door_closed, raw_clearn, raw_stopn, raw_startn, raw_keypad};
  assign k       = db_all[NUM_KEYS-1:0];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    debounce_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .SYNC_STAGES    (SYNC_STAGES),
      .IDLE_VALUE     (CH_IDLE[i])
    ) u_cell (
      .clock (clock),
      .resetn(resetn),
      .raw   (raw_all[i]),
      .level (db_all[i])
    );
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      startn      <= 1'b1;
      stopn       <= 1'b1;
      clearn      <= 1'b1;
      door_closed <= 1'b0;
    end else begin
      stopn       <= db_all[NUM_KEYS+1];
      clearn      <= db_all[NUM_KEYS+2];
      startn      <= db_all[NUM_KEYS] | ~db_all[NUM_KEYS+1] | ~db_all[NUM_KEYS+2];
      door_closed <= db_all[NUM_KEYS+3];
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      keypad    <= '0;
      multi_key <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (is_one_hot(k)) begin
            state  <= ONE;
            keypad <= k;
          end else if (k != '0) begin
            state     <= LOCK;
            multi_key <= 1'b1;
          end
        end
        ONE: begin
          if (k == '0) begin
            state  <= IDLE;
            keypad <= '0;
          end else if (k != keypad) begin
            state     <= LOCK;
            keypad    <= '0;
            multi_key <= 1'b1;
          end
        end
        LOCK: begin
          // Only a full release clears the lockout; a lone leftover key does not.
          keypad <= '0;
          if (k == '0) begin
            state     <= IDLE;
            multi_key <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          keypad    <= '0;
          multi_key <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_panel_input_conditioner.sv
// Directed plus randomized bench comparing every output each cycle with a windowed reference model.
module tb_panel_input_conditioner;

  localparam int DB   = 4;
  localparam int SYNC = 2;
  localparam int HLEN = SYNC + DB - 1;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic [9:0] raw_keypad = '0;
  logic       raw_startn = 1'b1, raw_stopn = 1'b1, raw_clearn = 1'b1, raw_door_closed = 1'b0;
  logic [9:0] keypad;
  logic       startn, stopn, clearn, door_closed, multi_key;

  int checks = 0;
  int failures = 0;

  // Reference model: channel order keys, startn, stopn, clearn, door.
  logic [13:0] hist [HLEN];
  logic [13:0] m_db;
  logic [9:0]  m_key;
  logic        m_locked;
  logic        m_startn, m_stopn, m_clearn, m_door;

  localparam logic [13:0] IDLE_LVL = {1'b0, 3'b111, 10'b0};

  panel_input_conditioner #(.DEBOUNCE_CYCLES(DB), .SYNC_STAGES(SYNC)) dut (
    .clock(clock), .resetn(resetn), .raw_keypad(raw_keypad), .raw_startn(raw_startn),
    .raw_stopn(raw_stopn), .raw_clearn(raw_clearn), .raw_door_closed(raw_door_closed),
    .keypad(keypad), .startn(startn), .stopn(stopn), .clearn(clearn),
    .door_closed(door_closed), .multi_key(multi_key)
  );

  always #5 clock = ~clock;

  task automatic model_reset();
    for (int j = 0; j < HLEN; j++) hist[j] = IDLE_LVL;
    m_db = IDLE_LVL;
    m_key = '0; m_locked = 1'b0;
    m_startn = 1'b1; m_stopn = 1'b1; m_clearn = 1'b1; m_door = 1'b0;
  endtask

  task automatic model_edge(input logic [13:0] r);
    logic [9:0] k;
    logic       all_diff;
    k = m_db[9:0];
    m_stopn  = m_db[11];
    m_clearn = m_db[12];
    m_startn = m_db[10] || !m_db[11] || !m_db[12];
    m_door   = m_db[13];
    // A single pressed key is accepted; anything ambiguous locks until all keys are up.
    if (k == 0) begin
      m_locked = 1'b0; m_key = '0;
    end else if (!m_locked) begin
      if (m_key == 0 && $countones(k) == 1) m_key = k;
      else if (k != m_key) begin m_key = '0; m_locked = 1'b1; end
    end
    // Level flips once the last DB synchronised samples all disagree with it.
    for (int c = 0; c < 14; c++) begin
      all_diff = 1'b1;
      for (int j = SYNC - 1; j <= SYNC + DB - 2; j++)
        if (hist[j][c] == m_db[c]) all_diff = 1'b0;
      if (all_diff) m_db[c] = ~m_db[c];
    end
    for (int j = HLEN - 1; j > 0; j--) hist[j] = hist[j-1];
    hist[0] = r;
  endtask

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("keypad", keypad, m_key);
    chk("multi_key", {9'b0, multi_key}, {9'b0, m_locked});
    chk("startn", {9'b0, startn}, {9'b0, m_startn});
    chk("stopn", {9'b0, stopn}, {9'b0, m_stopn});
    chk("clearn", {9'b0, clearn}, {9'b0, m_clearn});
    chk("door_closed", {9'b0, door_closed}, {9'b0, m_door});
  endtask

  task automatic tick();
    logic [13:0] r;
    r = {raw_door_closed, raw_clearn, raw_stopn, raw_startn, raw_keypad};
    @(posedge clock);
    if (!resetn) model_reset();
    else model_edge(r);
    #1;
    check_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    model_reset();
    raw_keypad = 10'h004;
    ticks(3);
    chk("rst_keypad", keypad, 10'h000);
    chk("rst_startn", {9'b0, startn}, 10'h001);
    chk("rst_door", {9'b0, door_closed}, 10'h000);
    chk("rst_multi", {9'b0, multi_key}, 10'h000);
    resetn = 1'b1;
    ticks(6);
    chk("key2_early", keypad, 10'h000);
    tick();
    chk("key2_lat7", keypad, 10'h004);
    raw_keypad = '0;
    ticks(9);

    // Bounce on key 5, then hold.
    for (int i = 0; i < 5; i++) begin
      raw_keypad = (i % 2 == 0) ? 10'h020 : 10'h000;
      if (i < 4) tick();
    end
    ticks(6);
    chk("key5_bounce_early", keypad, 10'h000);
    tick();
    chk("key5_lat7", keypad, 10'h020);
    raw_keypad = '0;
    ticks(9);

    // Two keys together lock out until every key is released.
    raw_keypad = 10'h088;
    ticks(7);
    chk("dual_multi", {9'b0, multi_key}, 10'h001);
    chk("dual_keypad", keypad, 10'h000);
    raw_keypad = 10'h008;
    ticks(10);
    chk("lock_hold", {9'b0, multi_key}, 10'h001);
    raw_keypad = '0;
    ticks(7);
    chk("lock_exit", {9'b0, multi_key}, 10'h000);
    raw_keypad = 10'h002;
    ticks(7);
    chk("idle_after_lock", keypad, 10'h002);
    raw_keypad = '0;
    ticks(9);

    // Second key added while first is held.
    raw_keypad = 10'h004;
    ticks(10);
    chk("key2_held", keypad, 10'h004);
    raw_keypad = 10'h204;
    ticks(7);
    chk("add9_keypad", keypad, 10'h000);
    chk("add9_multi", {9'b0, multi_key}, 10'h001);
    raw_keypad = '0;
    ticks(9);

    // Stop dominates start.
    raw_startn = 1'b0; raw_stopn = 1'b0;
    ticks(7);
    chk("stop_lat7", {9'b0, stopn}, 10'h000);
    chk("start_masked", {9'b0, startn}, 10'h001);
    raw_stopn = 1'b1;
    ticks(6);
    chk("start_early", {9'b0, startn}, 10'h001);
    tick();
    chk("start_after_stop", {9'b0, startn}, 10'h000);
    raw_clearn = 1'b0;
    ticks(7);
    chk("clear_masks_start", {9'b0, startn}, 10'h001);
    raw_startn = 1'b1; raw_clearn = 1'b1;
    ticks(9);

    // Door closed, then a one-cycle reset pulse.
    raw_door_closed = 1'b1;
    ticks(7);
    chk("door_lat7", {9'b0, door_closed}, 10'h001);
    resetn = 1'b0;
    #1;
    model_reset();
    chk("door_async_rst", {9'b0, door_closed}, 10'h000);
    tick();
    resetn = 1'b1;
    ticks(6);
    chk("door_redebounce_early", {9'b0, door_closed}, 10'h000);
    tick();
    chk("door_redebounce", {9'b0, door_closed}, 10'h001);

    // Randomized soak: mixed key patterns, button presses and short glitches.
    for (int seg = 0; seg < 70; seg++) begin
      case ($urandom_range(0, 3))
        0: raw_keypad = '0;
        1: raw_keypad = 10'(1 << $urandom_range(0, 9));
        2: raw_keypad = 10'((1 << $urandom_range(0, 9)) | (1 << $urandom_range(0, 9)));
        default: raw_keypad = 10'($urandom_range(0, 1023));
      endcase
      raw_startn = ($urandom_range(0, 3) != 0);
      raw_stopn  = ($urandom_range(0, 3) != 0);
      raw_clearn = ($urandom_range(0, 3) != 0);
      raw_door_closed = 1'($urandom_range(0, 1));
      ticks($urandom_range(1, 10));
      if ($urandom_range(0, 4) == 0) begin
        raw_keypad = raw_keypad ^ 10'(1 << $urandom_range(0, 9));
        ticks($urandom_range(1, 3));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/panel_input_conditioner.md
Name: panel_input_conditioner

Overview:
- Front-panel input stage directly upstream of the microwave top level.
- Synchronises and debounces the raw keypad, start/stop/clear buttons and door switch, then drives the top level's keypad, startn, stopn, clearn and door_closed inputs.
- Delivers clean, glitch-free levels: at most one keypad bit active, and a safe door state during reset.

Parameters:
- DEBOUNCE_CYCLES, 4 (simulation) / 200000 (board): consecutive stable synchronised samples needed to accept a new level; minimum 2.
- SYNC_STAGES, 2: synchroniser depth per raw input; minimum 2.

Ports:
- clock  in  1  system clock; all state on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- raw_keypad  in  10  bouncing key contacts, 1 = pressed, bit i = digit i.
- raw_startn  in  1  bouncing start button, 0 = pressed.
- raw_stopn  in  1  bouncing stop button, 0 = pressed.
- raw_clearn  in  1  bouncing clear button, 0 = pressed.
- raw_door_closed  in  1  bouncing door switch, 1 = closed.
- keypad  out  10  clean key vector: one-hot or all zero.
- startn  out  1  clean start, active-low.
- stopn  out  1  clean stop, active-low.
- clearn  out  1  clean clear, active-low.
- door_closed  out  1  clean door state.
- multi_key  out  1  high while keypad lockout is active.

Behaviour:
- Reset (asynchronous assert, synchronous deassert not required), all values registered:
  - keypad = 0, multi_key = 0, door_closed = 0.
  - startn = 1, stopn = 1, clearn = 1.
  - Synchroniser flops and stable states load the idle level of their channel: 0 for keys, 1 for button "n" inputs, 0 for door. All counters = 0.
- Channels: 14 independent channels (10 keys, 3 buttons, 1 door). Each is a SYNC_STAGES flop chain followed by a debounce cell.
- Debounce cell:
  - State is a stable bit plus a counter of width $clog2(DEBOUNCE_CYCLES).
  - Synchronised sample == stable: counter clears to 0. Any bounce restarts the count.
  - Sample != stable and counter < DEBOUNCE_CYCLES-1: counter increments.
  - Sample != stable and counter == DEBOUNCE_CYCLES-1: stable toggles and counter clears.
  - The counter never wraps.
- Latency: a raw change that is held appears on the outputs exactly SYNC_STAGES + DEBOUNCE_CYCLES + 1 rising edges after the first edge that samples it (5 + 2 = 7 with the defaults). Release has the same latency.
- Keypad lockout FSM, states IDLE / ONE / LOCK, evaluated on the debounced key vector k:
  - IDLE: k == 0 → stay. k one-hot → ONE, keypad = k. popcount(k) ≥ 2 → LOCK.
  - ONE: k == keypad → stay. k == 0 → IDLE, keypad = 0. Any other nonzero k → LOCK, keypad = 0.
  - LOCK: keypad = 0, multi_key = 1. Leave to IDLE only when k == 0. A later single key does not exit LOCK.
  - Outputs are registered: keypad and multi_key update on the same edge as the state.
- Buttons, applied to the debounced levels:
  - clearn and stopn pass through unchanged.
  - startn output is forced to 1 whenever debounced stopn == 0 or debounced clearn == 0 (stop/clear dominate start).
  - door_closed passes through. Door open therefore has the full debounce latency.
- Reset mid-operation: all state returns to reset values immediately. A key held across reset must re-debounce from the idle level.

Decomposition:
- Shared package: lockout state enum (IDLE, ONE, LOCK) and localparam NUM_KEYS = 10.
- One sub-module, debounce_cell (parameter DEBOUNCE_CYCLES, plus IDLE_VALUE for the reset level), instantiated 14 times via generate.
- Synchronisers live inside debounce_cell, one chain per cell.

Test Plan (DEBOUNCE_CYCLES = 4, SYNC_STAGES = 2):
- Reset held 3 cycles with raw_keypad = 10'h004 → keypad = 0, startn/stopn/clearn = 1, door_closed = 0, multi_key = 0. After release, keypad = 10'h004 exactly 7 edges later.
- raw_keypad bit 5 toggles 1,0,1,0,1 on consecutive cycles, then holds 1 → keypad remains 0 during the bounce. keypad = 10'h020 exactly 7 edges after the final rising sample.
- Bits 3 and 7 pressed together → keypad stays 0, multi_key = 1. Release bit 7 only → still locked with keypad = 0. Release bit 3 → multi_key = 0 and the FSM is in IDLE.
- Press 2, then press 9 while 2 is still held → keypad goes 10'h004 → 0 with multi_key = 1 once 9 is debounced.
- raw_startn = 0 and raw_stopn = 0 asserted on the same cycle → stopn = 0 after 7 edges, startn stays 1 throughout. Release stop, keep start held → startn = 0 seven edges after the stop release.
- Door raw 1 debounced to door_closed = 1, then resetn pulsed low for 1 cycle → door_closed = 0 immediately, then returns to 1 after 7 edges.
